pdh_cmd_ctrl: RTL and testbench



---
 rtl/pdh_ctrl_pkg.sv | 52 +++++
 rtl/pdh_cmd_ctrl_if.sv | 19 +
 rtl/pdh_cfg_bank.sv | 59 +++++
 rtl/pdh_cmd_ctrl.sv | 133 +++++++++++++
 tb/tb_pdh_cmd_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pdh_ctrl_pkg.sv
// Shared types for the PDH command sequencer: opcodes, status codes, FSM states
// and the packed layouts of the PS command/response words.
package pdh_ctrl_pkg;
  localparam int REG_WIDTH = 16;
  localparam int ADDR_W    = 4;

  localparam int TAG_BIT  = 31;
  localparam int OP_LSB   = 28;
  localparam int ADDR_LSB = 24;
  localparam int STAT_LSB = 24;
  localparam int SEQ_LSB  = 16;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_WR_SHADOW = 3'd1,
    OP_RD_SHADOW = 3'd2,
    OP_RD_ACTIVE = 3'd3,
    OP_COMMIT    = 3'd4,
    OP_SAMPLE    = 3'd5,
    OP_ILL6      = 3'd6,
    OP_ILL7      = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    ST_OK       = 4'd0,
    ST_BAD_OP   = 4'd1,
    ST_BAD_ADDR = 4'd2,
    ST_TIMEOUT  = 4'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_SMP
  } state_e;

  typedef struct packed {
    logic                  tag;
    opcode_e               op;
    logic [ADDR_W-1:0]     addr;
    logic [7:0]            rsvd;
    logic [REG_WIDTH-1:0]  data;
  } cmd_t;

  typedef struct packed {
    logic                  tag;
    opcode_e               op;
    status_e               status;
    logic [7:0]            seq;
    logic [REG_WIDTH-1:0]  data;
  } resp_t;
endpackage

// File: rtl/pdh_cmd_ctrl_if.sv
// PS GPIO command/response words plus the ADC sample stream feeding the sequencer.
interface pdh_cmd_ctrl_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [31:0]                 axi_from_ps_i;
  logic [31:0]                 axi_to_ps_o;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata_i;
  logic                        S_AXIS_tvalid_i;

  modport master (
    output axi_from_ps_i, S_AXIS_tdata_i, S_AXIS_tvalid_i,
    input  axi_to_ps_o
  );

  modport slave (
    input  axi_from_ps_i, S_AXIS_tdata_i, S_AXIS_tvalid_i,
    output axi_to_ps_o
  );
endinterface

// File: rtl/pdh_cfg_bank.sv
// Shadow/active configuration register bank; COMMIT copies the whole shadow
// bank into the active bank in one cycle and pulses cfg_update_o.
module pdh_cfg_bank
  import pdh_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [REG_WIDTH-1:0]          wr_data,
  input  logic [ADDR_W-1:0]             sh_raddr,
  output logic [REG_WIDTH-1:0]          sh_rdata,
  input  logic [ADDR_W-1:0]             act_raddr,
  output logic [REG_WIDTH-1:0]          act_rdata,
  input  logic                          commit,
  output logic [NUM_REGS*REG_WIDTH-1:0] cfg_o,
  output logic                          cfg_update_o
);
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] active_q, active_d;
  logic                               upd_q, upd_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    upd_d    = commit;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) shadow_d[i] = wr_data;
    end
    if (commit) active_d = shadow_q;
  end

  // Out-of-range addresses are filtered upstream; they simply match no entry here.
  always_comb begin
    sh_rdata  = '0;
    act_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sh_raddr == ADDR_W'(i))  sh_rdata  = shadow_q[i];
      if (act_raddr == ADDR_W'(i)) act_rdata = active_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      upd_q    <= upd_d;
    end
  end

  assign cfg_o        = active_q;
  assign cfg_update_o = upd_q;
endmodule

// File: rtl/pdh_cmd_ctrl.sv
// Tag-toggled PS command sequencer: IDLE -> EXEC (-> WAIT_SMP) -> IDLE, with an
// atomic response register and a shadow/active config bank behind it.
module pdh_cmd_ctrl
  import pdh_ctrl_pkg::*;
#(
  parameter int NUM_REGS         = 16,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  pdh_cmd_ctrl_if.slave                 bus,
  output logic [NUM_REGS*REG_WIDTH-1:0] cfg_o,
  output logic                          cfg_update_o,
  output logic                          busy_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  resp_t           resp_q, resp_d;
  logic            last_tag_q, last_tag_d;
  logic [7:0]      seq_q, seq_d;
  logic [TW-1:0]   cnt_q, cnt_d;

  cmd_t                 cmd_in;
  logic                 bad_addr;
  logic                 done;
  status_e              st;
  logic [REG_WIDTH-1:0] rdata;
  logic [REG_WIDTH-1:0] sh_rdata, act_rdata;
  logic                 wr_en, commit;
  logic                 unused_rsvd;

  assign cmd_in      = cmd_t'(bus.axi_from_ps_i);
  assign bad_addr    = ({28'b0, cmd_q.addr} >= 32'(NUM_REGS));
  assign wr_en       = (state_q == S_EXEC) && (cmd_q.op == OP_WR_SHADOW) && !bad_addr;
  assign commit      = (state_q == S_EXEC) && (cmd_q.op == OP_COMMIT);
  assign unused_rsvd = ^cmd_q.rsvd;

  pdh_cfg_bank #(.NUM_REGS(NUM_REGS)) u_bank (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (cmd_q.addr),
    .wr_data      (cmd_q.data),
    .sh_raddr     (cmd_q.addr),
    .sh_rdata     (sh_rdata),
    .act_raddr    (cmd_q.addr),
    .act_rdata    (act_rdata),
    .commit       (commit),
    .cfg_o        (cfg_o),
    .cfg_update_o (cfg_update_o)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    resp_d     = resp_q;
    last_tag_d = last_tag_q;
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    done       = 1'b0;
    st         = ST_OK;
    rdata      = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_in.tag != last_tag_q) begin
          cmd_d      = cmd_in;
          last_tag_d = cmd_in.tag;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done    = 1'b1;
        case (cmd_q.op)
          OP_NOP, OP_COMMIT: begin end
          OP_WR_SHADOW: if (bad_addr) st = ST_BAD_ADDR;
          OP_RD_SHADOW: if (bad_addr) st = ST_BAD_ADDR; else rdata = sh_rdata;
          OP_RD_ACTIVE: if (bad_addr) st = ST_BAD_ADDR; else rdata = act_rdata;
          OP_SAMPLE: begin
            done    = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT_SMP;
          end
          default: st = ST_BAD_OP;
        endcase
      end
      S_WAIT_SMP: begin
        if (bus.S_AXIS_tvalid_i) begin
          done    = 1'b1;
          rdata   = cmd_q.data[0] ? bus.S_AXIS_tdata_i[31:16] : bus.S_AXIS_tdata_i[15:0];
          state_d = S_IDLE;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Last of TIMEOUT_CYCLES empty waiting cycles.
          done    = 1'b1;
          st      = ST_TIMEOUT;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      seq_d  = seq_q + 8'd1;
      resp_d = '{tag: cmd_q.tag, op: cmd_q.op, status: st, seq: seq_q + 8'd1, data: rdata};
    end
  end

  // Sampling the live tag in reset keeps release from looking like a new command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      resp_q     <= resp_t'({bus.axi_from_ps_i[TAG_BIT], 31'b0});
      last_tag_q <= bus.axi_from_ps_i[TAG_BIT];
      seq_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      resp_q     <= resp_d;
      last_tag_q <= last_tag_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.axi_to_ps_o = resp_q;
  assign busy_o          = (state_q != S_IDLE);
endmodule

// File: tb/tb_pdh_cmd_ctrl.sv
// Directed bench for pdh_cmd_ctrl: a vector table for single commands plus
// hand sequences for commit, sampling, timeout, busy flips, seq wrap and reset.
module tb_pdh_cmd_ctrl;
  localparam int NR = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdh_cmd_ctrl_if #(.AXIS_TDATA_WIDTH(32)) bus ();
  logic [NR*16-1:0] cfg;
  logic             cfg_upd;
  logic             busy;

  pdh_cmd_ctrl #(.NUM_REGS(NR), .AXIS_TDATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cfg_o        (cfg),
    .cfg_update_o (cfg_upd),
    .busy_o       (busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [3:0]  st;
    logic [15:0] d;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        tag;
  logic        t1;
  logic [7:0]  seq;
  logic [31:0] exp_resp;
  vec_t        vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] data);
    tag = ~tag;
    bus.axi_from_ps_i = {tag, op, addr, 8'h5A, data};
  endtask

  task automatic expect_rsp(input string name, input logic t, input logic [2:0] op,
                            input logic [3:0] st, input logic [15:0] d);
    seq      = seq + 8'd1;
    exp_resp = {t, op, st, seq, d};
    chk(name, bus.axi_to_ps_o, exp_resp);
  endtask

  task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] addr,
                         input logic [15:0] data, input logic [3:0] st, input logic [15:0] d);
    send(op, addr, data);
    tick(1);
    chk({name, "/busy1"}, {31'b0, busy}, 32'd1);
    chk({name, "/hold"}, bus.axi_to_ps_o, exp_resp);
    tick(1);
    chk({name, "/busy0"}, {31'b0, busy}, 32'd0);
    expect_rsp({name, "/rsp"}, tag, op, st, d);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 4'd3, 16'hBEEF, 4'd0, 16'h0000};
    vecs[1]  = '{3'd2, 4'd3, 16'h0000, 4'd0, 16'hBEEF};
    vecs[2]  = '{3'd3, 4'd3, 16'h0000, 4'd0, 16'h0000};
    vecs[3]  = '{3'd1, 4'd7, 16'h1357, 4'd0, 16'h0000};
    vecs[4]  = '{3'd2, 4'd7, 16'hFFFF, 4'd0, 16'h1357};
    vecs[5]  = '{3'd1, 4'd8, 16'hDEAD, 4'd2, 16'h0000};
    vecs[6]  = '{3'd1, 4'd9, 16'hDEAD, 4'd2, 16'h0000};
    vecs[7]  = '{3'd2, 4'd9, 16'h0000, 4'd2, 16'h0000};
    vecs[8]  = '{3'd3, 4'd15, 16'h0000, 4'd2, 16'h0000};
    vecs[9]  = '{3'd2, 4'd0, 16'h0000, 4'd0, 16'h0000};
    vecs[10] = '{3'd2, 4'd1, 16'h0000, 4'd0, 16'h0000};
    vecs[11] = '{3'd7, 4'd3, 16'h1111, 4'd1, 16'h0000};
    vecs[12] = '{3'd6, 4'd0, 16'h2222, 4'd1, 16'h0000};
    vecs[13] = '{3'd0, 4'd0, 16'hFFFF, 4'd0, 16'h0000};

    // Reset with the PS tag already at 1.
    bus.axi_from_ps_i   = 32'h8000_0000;
    bus.S_AXIS_tdata_i  = '0;
    bus.S_AXIS_tvalid_i = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst/resp", bus.axi_to_ps_o, 32'h8000_0000);
    chk("rst/cfg", {31'b0, |cfg}, 32'd0);
    chk("rst/busy", {31'b0, busy}, 32'd0);
    chk("rst/upd", {31'b0, cfg_upd}, 32'd0);
    tick(4);
    chk("rst/noexec_resp", bus.axi_to_ps_o, 32'h8000_0000);
    chk("rst/noexec_busy", {31'b0, busy}, 32'd0);
    tag = 1'b1;
    seq = 8'd0;
    exp_resp = 32'h8000_0000;

    for (int i = 0; i < 14; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].st, vecs[i].d);
    chk("errs/cfg_untouched", {31'b0, |cfg}, 32'd0);

    // COMMIT: active bank and update pulse land at cycle 2, pulse lasts one cycle.
    send(3'd4, 4'd0, 16'h0000);
    tick(1);
    chk("commit/c1_busy", {31'b0, busy}, 32'd1);
    chk("commit/c1_upd", {31'b0, cfg_upd}, 32'd0);
    chk("commit/c1_cfg3", {16'b0, cfg[63:48]}, 32'h0);
    tick(1);
    chk("commit/c2_upd", {31'b0, cfg_upd}, 32'd1);
    chk("commit/c2_cfg3", {16'b0, cfg[63:48]}, 32'hBEEF);
    chk("commit/c2_cfg7", {16'b0, cfg[127:112]}, 32'h1357);
    chk("commit/c2_cfg0", {16'b0, cfg[15:0]}, 32'h0);
    expect_rsp("commit/rsp", tag, 3'd4, 4'd0, 16'h0000);
    tick(1);
    chk("commit/c3_upd", {31'b0, cfg_upd}, 32'd0);
    run_cmd("rd_active3", 3'd3, 4'd3, 16'h0, 4'd0, 16'hBEEF);
    run_cmd("rd_active7", 3'd3, 4'd7, 16'h0, 4'd0, 16'h1357);

    // SAMPLE ch B, tvalid first at cycle 5 -> response at cycle 6.
    bus.S_AXIS_tdata_i = 32'h1234_5678;
    send(3'd5, 4'd0, 16'h0001);
    tick(5);
    chk("smpB/c5_busy", {31'b0, busy}, 32'd1);
    chk("smpB/c5_hold", bus.axi_to_ps_o, exp_resp);
    bus.S_AXIS_tvalid_i = 1'b1;
    tick(1);
    bus.S_AXIS_tvalid_i = 1'b0;
    expect_rsp("smpB/rsp", tag, 3'd5, 4'd0, 16'h1234);
    chk("smpB/c6_busy", {31'b0, busy}, 32'd0);

    // SAMPLE ch A with tvalid already high in IDLE/EXEC: only the cycle-2 beat counts.
    bus.S_AXIS_tdata_i  = 32'hAAAA_5555;
    bus.S_AXIS_tvalid_i = 1'b1;
    send(3'd5, 4'd0, 16'h0000);
    tick(2);
    chk("smpA/c2_busy", {31'b0, busy}, 32'd1);
    bus.S_AXIS_tdata_i = 32'h0000_C3C3;
    tick(1);
    bus.S_AXIS_tvalid_i = 1'b0;
    expect_rsp("smpA/rsp", tag, 3'd5, 4'd0, 16'hC3C3);

    // Timeout with tvalid low: response at cycle 2 + TO.
    bus.S_AXIS_tdata_i = 32'hFFFF_FFFF;
    send(3'd5, 4'd0, 16'h0000);
    tick(TO + 1);
    chk("tmo/c17_busy", {31'b0, busy}, 32'd1);
    chk("tmo/c17_hold", bus.axi_to_ps_o, exp_resp);
    tick(1);
    expect_rsp("tmo/rsp", tag, 3'd5, 4'd3, 16'h0000);
    chk("tmo/c18_busy", {31'b0, busy}, 32'd0);

    // Tag flip while busy is serviced right after the current response.
    bus.S_AXIS_tdata_i = 32'h0000_4321;
    send(3'd5, 4'd0, 16'h0000);
    t1 = tag;
    tick(2);
    send(3'd3, 4'd3, 16'h0000);
    tick(2);
    bus.S_AXIS_tvalid_i = 1'b1;
    tick(1);
    bus.S_AXIS_tvalid_i = 1'b0;
    expect_rsp("flip/smp_rsp", t1, 3'd5, 4'd0, 16'h4321);
    chk("flip/c5_busy", {31'b0, busy}, 32'd0);
    tick(1);
    chk("flip/c6_busy", {31'b0, busy}, 32'd1);
    tick(1);
    expect_rsp("flip/rd_rsp", tag, 3'd3, 4'd0, 16'hBEEF);

    // Seq counter wraps 255 -> 0.
    while (seq != 8'd255) run_cmd("nop_fill", 3'd0, 4'd0, 16'h0, 4'd0, 16'h0);
    run_cmd("nop_wrap", 3'd0, 4'd0, 16'h0, 4'd0, 16'h0);
    chk("seq_wrap", {24'b0, bus.axi_to_ps_o[23:16]}, 32'd0);

    // Reset during EXEC aborts the command without a response.
    send(3'd2, 4'd3, 16'h0000);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("midrst/resp", bus.axi_to_ps_o, {tag, 31'b0});
    chk("midrst/busy", {31'b0, busy}, 32'd0);
    chk("midrst/cfg", {31'b0, |cfg}, 32'd0);
    rst = 1'b0;
    tick(3);
    chk("midrst/quiet", bus.axi_to_ps_o, {tag, 31'b0});
    seq = 8'd0;
    exp_resp = {tag, 31'b0};
    run_cmd("midrst/shadow_clr", 3'd2, 4'd3, 16'h0, 4'd0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
